// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the RAM pins around the data-memory arbiter.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_dout,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_dout,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous-read data RAM between the CPU
// (port 0) and the DMA/loader (port 1); one command in flight, plus a contention counter.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit FIXED_PRI = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  dmem_arbiter_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;
  logic              cmd_port;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              tie;
  logic              any_req;
  logic              winner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // NOTE: every signal gets a value before any condition, so no latch can be inferred.
  always_comb begin
    tie     = bus.m0_req & bus.m1_req;
    any_req = bus.m0_req | bus.m1_req;
    winner  = bus.m1_req;
    if (tie) winner = FIXED_PRI ? 1'b0 : ~last_grant;
    win_we    = winner ? bus.m1_we    : bus.m0_we;
    win_addr  = winner ? bus.m1_addr  : bus.m0_addr;
    win_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
  end

  // The command registers are the RAM address/data pins, so they hold between accesses.
  assign bus.ram_addr = cmd_addr;
  assign bus.ram_din  = cmd_wdata;

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      cmd_port      <= 1'b0;
      cmd_we        <= 1'b0;
      cmd_addr      <= '0;
      cmd_wdata     <= '0;
      busy          <= 1'b0;
      conflict_cnt  <= '0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
    end else begin
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (tie && (conflict_cnt != {CNT_W{1'b1}}))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
          if (any_req) begin
            cmd_port   <= winner;
            cmd_we     <= win_we;
            cmd_addr   <= win_addr;
            cmd_wdata  <= win_wdata;
            last_grant <= winner;
            state      <= ISSUE;
            busy       <= 1'b1;
            // Strobes are loaded here so they are flop outputs during ISSUE.
            bus.ram_en <= 1'b1;
            bus.ram_we <= win_we;
            bus.m0_gnt <= ~winner;
            bus.m1_gnt <= winner;
          end
        end
        ISSUE: begin
          state <= cmd_we ? IDLE : RDATA;
          busy  <= ~cmd_we;
        end
        RDATA: begin
          if (cmd_port) begin
            bus.m1_rdata  <= bus.ram_dout;
            bus.m1_rvalid <= 1'b1;
          end else begin
            bus.m0_rdata  <= bus.ram_dout;
            bus.m0_rvalid <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance and a fixed-priority 4-bit-counter instance,
// each with its own RAM, checked every cycle against a transaction-timeline reference model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic        en;
    logic        we;
    logic        busy;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    cmd_t c0;
    cmd_t c1;
    obs_t exp;
  } vec_t;

  cmd_t st [2][2];
  cmd_t nx [2][2];
  logic rst_nx;
  bit   hold [2][2];
  obs_t last_obs [2];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  logic        busy0, busy1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRI(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .busy(busy0), .conflict_cnt(cnt0));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRI(1'b1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .busy(busy1), .conflict_cnt(cnt1));

  assign b0.m0_req = st[0][0].req;  assign b0.m0_we = st[0][0].we;
  assign b0.m0_addr = st[0][0].addr; assign b0.m0_wdata = st[0][0].wdata;
  assign b0.m1_req = st[0][1].req;  assign b0.m1_we = st[0][1].we;
  assign b0.m1_addr = st[0][1].addr; assign b0.m1_wdata = st[0][1].wdata;
  assign b1.m0_req = st[1][0].req;  assign b1.m0_we = st[1][0].we;
  assign b1.m0_addr = st[1][0].addr; assign b1.m0_wdata = st[1][0].wdata;
  assign b1.m1_req = st[1][1].req;  assign b1.m1_we = st[1][1].we;
  assign b1.m1_addr = st[1][1].addr; assign b1.m1_wdata = st[1][1].wdata;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {24'hA5C3E1, a};
  endfunction

  // Synchronous-read RAMs; never-written words read back as init_word(addr).
  logic [31:0] ram0 [256];
  logic [31:0] ram1 [256];
  bit   [255:0] wr0, wr1;
  always @(posedge clk) begin
    if (b0.ram_en) begin
      if (b0.ram_we) begin
        ram0[b0.ram_addr[7:0]] <= b0.ram_din;
        wr0[b0.ram_addr[7:0]]  <= 1'b1;
      end else
        b0.ram_dout <= wr0[b0.ram_addr[7:0]] ? ram0[b0.ram_addr[7:0]] : init_word(b0.ram_addr[7:0]);
    end
    if (b1.ram_en) begin
      if (b1.ram_we) begin
        ram1[b1.ram_addr[7:0]] <= b1.ram_din;
        wr1[b1.ram_addr[7:0]]  <= 1'b1;
      end else
        b1.ram_dout <= wr1[b1.ram_addr[7:0]] ? ram1[b1.ram_addr[7:0]] : init_word(b1.ram_addr[7:0]);
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, d, cyc, got, want);
    end
  endtask

  task automatic compare(input string pfx, input int d, input obs_t a, input obs_t e);
    check({pfx, ".gnt"},    d, 32'(a.gnt),    32'(e.gnt));
    check({pfx, ".rvalid"}, d, 32'(a.rvalid), 32'(e.rvalid));
    check({pfx, ".ram_en"}, d, 32'(a.en),     32'(e.en));
    check({pfx, ".ram_we"}, d, 32'(a.we),     32'(e.we));
    check({pfx, ".busy"},   d, 32'(a.busy),   32'(e.busy));
    check({pfx, ".addr"},   d, a.addr,        e.addr);
    check({pfx, ".din"},    d, a.din,         e.din);
    check({pfx, ".rdata0"}, d, a.rd0,         e.rd0);
    check({pfx, ".rdata1"}, d, a.rd1,         e.rd1);
    check({pfx, ".cnt"},    d, 32'(a.cnt),    32'(e.cnt));
  endtask

  task automatic sample(input int d, output obs_t o);
    if (d == 0) begin
      o.gnt = {b0.m1_gnt, b0.m0_gnt};  o.rvalid = {b0.m1_rvalid, b0.m0_rvalid};
      o.en = b0.ram_en; o.we = b0.ram_we; o.busy = busy0;
      o.addr = b0.ram_addr; o.din = b0.ram_din; o.rd0 = b0.m0_rdata; o.rd1 = b0.m1_rdata;
      o.cnt = cnt0;
    end else begin
      o.gnt = {b1.m1_gnt, b1.m0_gnt};  o.rvalid = {b1.m1_rvalid, b1.m0_rvalid};
      o.en = b1.ram_en; o.we = b1.ram_we; o.busy = busy1;
      o.addr = b1.ram_addr; o.din = b1.ram_din; o.rd0 = b1.m0_rdata; o.rd1 = b1.m1_rdata;
      o.cnt = {12'd0, cnt1};
    end
  endtask

  // Reference model: each capture schedules its grant cycle, its read-return cycle and the
  // cycle the arbiter is free again; outputs follow from those cycle numbers.
  int          free_at [2], issue_c [2], rv_c [2], cnt_m [2];
  int          cnt_max [2] = '{65535, 15};
  bit          fixed   [2] = '{1'b0, 1'b1};
  int          last    [2];
  int          m_port  [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2], m_din [2], pend [2];
  logic [31:0] m_rd    [2][2];
  logic [31:0] ref_mem [2][256];

  task automatic model_reset(input int d);
    free_at[d] = 0; issue_c[d] = -1; rv_c[d] = -1; cnt_m[d] = 0; last[d] = 1;
    m_port[d] = 0; m_we[d] = 1'b0; m_addr[d] = '0; m_din[d] = '0;
    m_rd[d][0] = '0; m_rd[d][1] = '0;
  endtask

  task automatic model_expect(input int d, output obs_t e);
    if (cyc == rv_c[d]) m_rd[d][m_port[d]] = pend[d];
    e = '0;
    if (cyc == issue_c[d]) begin
      e.gnt = (m_port[d] == 1) ? 2'b10 : 2'b01;
      e.en  = 1'b1;
      e.we  = m_we[d];
    end
    if (cyc == rv_c[d]) e.rvalid = (m_port[d] == 1) ? 2'b10 : 2'b01;
    e.busy = (cyc >= issue_c[d]) && (cyc < free_at[d]);
    e.addr = m_addr[d]; e.din = m_din[d];
    e.rd0 = m_rd[d][0]; e.rd1 = m_rd[d][1];
    e.cnt = 16'(cnt_m[d]);
  endtask

  task automatic model_step(input int d);
    bit   r0, r1;
    int   w;
    cmd_t c;
    if (cyc < free_at[d]) return;
    r0 = st[d][0].req;
    r1 = st[d][1].req;
    if (r0 && r1 && cnt_m[d] < cnt_max[d]) cnt_m[d]++;
    if (!(r0 || r1)) return;
    if (r0 && r1) w = fixed[d] ? 0 : 1 - last[d];
    else          w = r1 ? 1 : 0;
    c = st[d][w];
    last[d] = w; m_port[d] = w; m_we[d] = c.we; m_addr[d] = c.addr; m_din[d] = c.wdata;
    issue_c[d] = cyc + 1;
    if (c.we) begin
      ref_mem[d][c.addr[7:0]] = c.wdata;
      free_at[d] = cyc + 2;
    end else begin
      pend[d]    = ref_mem[d][c.addr[7:0]];
      rv_c[d]    = cyc + 3;
      free_at[d] = cyc + 3;
    end
  endtask

  // One clock: drive staged inputs just after the edge, check both DUTs at the falling edge.
  task automatic run_cycle();
    obs_t a, e;
    @(posedge clk);
    #1;
    rst = rst_nx;
    st  = nx;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst) model_reset(d);
      model_expect(d, e);
      sample(d, a);
      compare("cyc", d, a, e);
      last_obs[d] = a;
      for (int p = 0; p < 2; p++) if (e.gnt[p]) hold[d][p] = 1'b0;
      if (rst) model_step(d);
    end
    cyc++;
  endtask

  task automatic gen(input int d, input int p, input int pct, input int wr_pct, input int drop_pct);
    if (hold[d][p]) begin
      if (int'($urandom_range(99)) < drop_pct) begin
        hold[d][p]   = 1'b0;
        nx[d][p].req = 1'b0;
      end
    end else if (int'($urandom_range(99)) < pct) begin
      hold[d][p]     = 1'b1;
      nx[d][p].req   = 1'b1;
      nx[d][p].we    = int'($urandom_range(99)) < wr_pct;
      nx[d][p].addr  = 32'($urandom_range(15));
      nx[d][p].wdata = $urandom;
    end else begin
      nx[d][p].req  = 1'b0;
      nx[d][p].we   = 1'($urandom_range(1));
      nx[d][p].addr = $urandom;
    end
  endtask

  function automatic cmd_t cm(input logic r, input logic w, input logic [31:0] a, input logic [31:0] dt);
    cmd_t c;
    c.req = r; c.we = w; c.addr = a; c.wdata = dt;
    return c;
  endfunction

  function automatic vec_t vec(input cmd_t c0, input cmd_t c1, input logic [1:0] g, input logic [1:0] v,
                               input logic en, input logic we, input logic bsy, input logic [31:0] addr,
                               input logic [31:0] din, input logic [31:0] rd0, input logic [31:0] rd1,
                               input logic [15:0] cnt);
    vec_t t;
    t.c0 = c0; t.c1 = c1;
    t.exp.gnt = g; t.exp.rvalid = v; t.exp.en = en; t.exp.we = we; t.exp.busy = bsy;
    t.exp.addr = addr; t.exp.din = din; t.exp.rd0 = rd0; t.exp.rd1 = rd1; t.exp.cnt = cnt;
    return t;
  endfunction

  localparam logic [31:0] A = 32'h10, B = 32'h20, DA = 32'hDEADBEEF, DB = 32'h12345678;

  initial begin
    vec_t tbl [11];
    cmd_t z, r0a, r1b;
    obs_t o;
    int   g [2][2];
    bit   seen;

    z   = cm(0, 0, 0, 0);
    r0a = cm(1, 0, A, 0);
    r1b = cm(1, 0, B, 0);
    // Tie right after reset goes to m0, next tie to m1; then read-backs on each port.
    tbl[0]  = vec(cm(1,1,A,DA), cm(1,1,B,DB), 2'b00, 2'b00, 0,0,0, 0, 0,  0,  0,  0);
    tbl[1]  = vec(cm(1,1,A,DA), cm(1,1,B,DB), 2'b01, 2'b00, 1,1,1, A, DA, 0,  0,  1);
    tbl[2]  = vec(r0a,          cm(1,1,B,DB), 2'b00, 2'b00, 0,0,0, A, DA, 0,  0,  1);
    tbl[3]  = vec(r0a,          cm(1,1,B,DB), 2'b10, 2'b00, 1,1,1, B, DB, 0,  0,  2);
    tbl[4]  = vec(r0a,          z,            2'b00, 2'b00, 0,0,0, B, DB, 0,  0,  2);
    tbl[5]  = vec(r0a,          z,            2'b01, 2'b00, 1,0,1, A, 0,  0,  0,  2);
    tbl[6]  = vec(z,            z,            2'b00, 2'b00, 0,0,1, A, 0,  0,  0,  2);
    tbl[7]  = vec(z,            r1b,          2'b00, 2'b01, 0,0,0, A, 0,  DA, 0,  2);
    tbl[8]  = vec(z,            r1b,          2'b10, 2'b00, 1,0,1, B, 0,  DA, 0,  2);
    tbl[9]  = vec(z,            z,            2'b00, 2'b00, 0,0,1, B, 0,  DA, 0,  2);
    tbl[10] = vec(z,            z,            2'b00, 2'b10, 0,0,0, B, 0,  DA, DB, 2);

    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      for (int i = 0; i < 256; i++) ref_mem[d][i] = init_word(8'(i));
      for (int p = 0; p < 2; p++) begin
        st[d][p] = '0; nx[d][p] = '0; hold[d][p] = 1'b0; g[d][p] = 0;
      end
    end

    // Reset held with both ports requesting: everything stays quiet.
    rst_nx = 1'b0;
    for (int d = 0; d < 2; d++) begin
      nx[d][0] = cm(1, 1, 32'h5, 32'h55);
      nx[d][1] = cm(1, 0, 32'h6, 0);
    end
    for (int i = 0; i < 3; i++) run_cycle();
    check("rst.ram_en", 0, 32'(last_obs[0].en), 0);
    check("rst.busy",   1, 32'(last_obs[1].busy), 0);

    // Directed vectors on the round-robin instance.
    rst_nx = 1'b1;
    nx[1][0] = z; nx[1][1] = z;
    for (int i = 0; i < 11; i++) begin
      nx[0][0] = tbl[i].c0;
      nx[0][1] = tbl[i].c1;
      run_cycle();
      sample(0, o);
      compare($sformatf("tbl%0d", i), 0, o, tbl[i].exp);
    end

    // Reset during RDATA: the read is dropped, then a fresh read returns the stored word.
    nx[0][0] = r1b; nx[0][1] = z;
    nx[0][0].req = 1'b1;
    run_cycle();
    run_cycle();
    nx[0][0] = z;
    rst_nx = 1'b0;
    run_cycle();
    check("midrst.rvalid", 0, 32'(last_obs[0].rvalid), 0);
    rst_nx = 1'b1;
    run_cycle();
    check("midrst.rvalid_after", 0, 32'(last_obs[0].rvalid), 0);
    check("midrst.busy_after",   0, 32'(last_obs[0].busy), 0);
    nx[0][0] = cm(1, 0, B, 0);
    run_cycle();
    run_cycle();
    nx[0][0] = z;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      run_cycle();
      if (last_obs[0].rvalid[0]) begin
        seen = 1'b1;
        check("midrst.rdata", 0, last_obs[0].rd0, DB);
      end
    end
    check("midrst.rvalid_seen", 0, 32'(seen), 1);

    // Both ports reading continuously: alternation on u0, starvation and saturation on u1.
    for (int i = 0; i < 135; i++) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) gen(d, p, 100, 0, 0);
      run_cycle();
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) g[d][p] += int'(last_obs[d].gnt[p]);
    end
    check("rr.balance",   0, 32'((g[0][0] - g[0][1] <= 1) && (g[0][1] - g[0][0] <= 1)), 1);
    check("rr.count",     0, 32'(g[0][0] + g[0][1] >= 40), 1);
    check("fp.m1_starve", 1, 32'(g[1][1]), 0);
    check("fp.m0_count",  1, 32'(g[1][0] >= 40), 1);
    check("fp.cnt_sat",   1, 32'(last_obs[1].cnt), 15);

    // m0 stops requesting on u1: m1 must be granted at the next arbitration.
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      gen(1, 0, 0, 0, 0);
      gen(1, 1, 100, 0, 0);
      gen(0, 0, 100, 0, 0);
      gen(0, 1, 100, 0, 0);
      run_cycle();
      seen = last_obs[1].gnt[1];
    end
    check("fp.m1_after_drop", 1, 32'(seen), 1);

    // Random traffic: mixed reads/writes, uneven request rates, occasional early withdrawal.
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) gen(d, p, 30 + 25 * p, 50, 5);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter and access sequencer that shares the single-port, synchronous-read data RAM between the CPU load/store path (port 0) and a DMA/program-loader path (port 1). It sits between the requesters and the RAM's addr/din/write_en/data_out pins. It captures one command at a time, drives the RAM for exactly one cycle, and returns read data through a registered valid pulse. It also counts contention cycles for performance monitoring.

## Interface
- ADDR_W, 32, address width passed to RAM
- DATA_W, 32, data width
- FIXED_PRI, 0, 0 = round-robin; 1 = port 0 always wins ties
- CNT_W, 16, width of contention counter

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- m0_req, m1_req  in  1  request; held with command until matching gnt
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_W  word address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_gnt, m1_gnt  out  1  command accepted; one-cycle pulse
- m0_rvalid, m1_rvalid  out  1  read data valid; one-cycle pulse
- m0_rdata, m1_rdata  out  DATA_W  read data, held until next read for that port
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0
- busy  out  1  state != IDLE
- conflict_cnt  out  CNT_W  saturating count of IDLE cycles with both req high

## Operation
- FSM states: IDLE, ISSUE, RDATA.
- IDLE: if any req, select winner, capture we/addr/wdata and port id into command registers, go ISSUE. Otherwise stay.
- Winner: single requester wins. On a tie, FIXED_PRI=1 picks port 0. Otherwise the port not in last_grant wins. last_grant updates to winner on capture.
- ISSUE: ram_en=1, ram_we=captured we, ram_addr/ram_din from command registers. Selected mX_gnt=1. Write goes to IDLE; read goes to RDATA.
- RDATA: capture ram_dout into the selected mX_rdata, set mX_rvalid for the next cycle, go IDLE.
- Outside ISSUE: ram_en=0, ram_we=0. ram_addr/ram_din hold the last captured value.
- Captured command is committed: deasserting req after capture does not abort it.
- A requester that drops req before capture is ignored.
- Requester may present its next command in the cycle after gnt. The arbiter samples it at the next IDLE.
- conflict_cnt increments in IDLE when m0_req & m1_req. It saturates at all-ones and does not wrap.
- Never both gnt high; never both rvalid high; at most one command outstanding.

## Timing
- Reset (rst=0, async): state=IDLE, last_grant=port 1 (port 0 wins first tie). All gnt, rvalid, ram_en, ram_we, busy=0. rdata, ram_addr, ram_din, conflict_cnt=0.
- Reset mid-transaction drops the command with no gnt or rvalid; RAM write is suppressed if not yet in ISSUE.
- Write: req sampled in IDLE at edge T. ISSUE during cycle T+1 (gnt, ram_we). IDLE at T+2. Throughput: 1 write per 2 cycles.
- Read: captured at T. ISSUE at T+1. RDATA at T+2 (ram_dout valid). rvalid and rdata at T+3 while state is IDLE. A new command can be captured at the end of T+3. Throughput: 1 read per 3 cycles.
- gnt and rvalid are registered-state decodes, glitch-free, exactly one cycle wide.
- Simultaneous rvalid for one port and new capture in the same cycle is legal.

## Test plan
- Reset: hold rst=0 with reqs active → all outputs 0, busy=0, no ram_en. Release → first tie grants m0.
- Single write then read: m0 write addr=0x10 data=0xDEADBEEF → m0_gnt and ram_we in the cycle after req. Then m0 read 0x10 → m0_rvalid with rdata=0xDEADBEEF 3 cycles after capture.
- Round-robin: both ports request continuously with reads → grants alternate m0,m1,m0,m1. Each port's rdata matches its own address. conflict_cnt increments once per arbitration.
- FIXED_PRI=1: both request continuously → m0 granted every arbitration, m1 starved until m0_req drops, then m1 granted next IDLE.
- Reset mid-read: assert rst=0 during RDATA → no rvalid. State IDLE after release. Subsequent read returns correct data.
- Saturation: CNT_W=4, hold both reqs for 40 arbitrations → conflict_cnt stops at 15.
